// File: rtl/event_encoder_8_3.sv
// Registered 8-to-3 priority event encoder: sticky request flags drained
// lowest-index-first as binary codes over a valid/ready handshake.
module event_encoder_8_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e     state_q;
  logic [2:0] code_q;
  logic       valid_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic       overflow_q;
  logic       overflow_d;
  logic       accept;
  logic [7:0] set_v;
  logic [7:0] clr_v;
  logic [2:0] lsb_idx;

  assign accept = (state_q == PRESENT) && ready;
  assign set_v  = enable ? req : 8'h00;

  always_comb begin
    clr_v = 8'h00;
    if (accept) clr_v[code_q] = 1'b1;
  end

  // Set after clear, so a new event on the accepted line survives.
  assign pending_d  = (pending_q & ~clr_v) | set_v;
  assign overflow_d = |(set_v & pending_q & ~clr_v);

  always_comb begin
    lsb_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) lsb_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= 3'd0;
      valid_q    <= 1'b0;
      pending_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      unique case (state_q)
        IDLE: begin
          if (pending_q != 8'h00) begin
            code_q  <= lsb_idx;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_encoder_8_3.sv
// Directed bench for event_encoder_8_3: capture, priority, stall,
// preemption, overflow/set-wins, enable gating and async reset.
module tb_event_encoder_8_3;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  event_encoder_8_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .ready    (ready),
    .code     (code),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [2:0] c, input logic [7:0] p,
                         input logic o);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
    if (v) chk({tag, ".code"}, {5'd0, code}, {5'd0, c});
    chk({tag, ".pending"}, pending, p);
    chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, o});
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk({"rst"}, {5'd0, code}, 8'h00);
    chk_out("rst", 1'b0, 3'd0, 8'h00, 1'b0);

    // single event
    enable = 1'b1;
    req    = 8'h20;
    ready  = 1'b1;
    tick();
    req = 8'h00;
    chk_out("se1", 1'b0, 3'd0, 8'h20, 1'b0);
    tick();
    chk_out("se2", 1'b1, 3'd5, 8'h20, 1'b0);
    tick();
    chk_out("se3", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk_out("se4", 1'b0, 3'd0, 8'h00, 1'b0);

    // priority and stall
    ready = 1'b0;
    req   = 8'h91;
    tick();
    req = 8'h00;
    chk_out("pr1", 1'b0, 3'd0, 8'h91, 1'b0);
    tick();
    chk_out("pr2", 1'b1, 3'd0, 8'h91, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("stall", 1'b1, 3'd0, 8'h91, 1'b0);
    end
    ready = 1'b1;
    tick();
    chk_out("pr3", 1'b0, 3'd0, 8'h90, 1'b0);
    tick();
    chk_out("pr4", 1'b1, 3'd4, 8'h90, 1'b0);
    tick();
    chk_out("pr5", 1'b0, 3'd0, 8'h80, 1'b0);
    tick();
    chk_out("pr6", 1'b1, 3'd7, 8'h80, 1'b0);
    tick();
    chk_out("pr7", 1'b0, 3'd0, 8'h00, 1'b0);

    // no preemption
    ready = 1'b0;
    req   = 8'h40;
    tick();
    req = 8'h00;
    tick();
    chk_out("np1", 1'b1, 3'd6, 8'h40, 1'b0);
    req = 8'h02;
    tick();
    req = 8'h00;
    chk_out("np2", 1'b1, 3'd6, 8'h42, 1'b0);
    ready = 1'b1;
    tick();
    chk_out("np3", 1'b0, 3'd0, 8'h02, 1'b0);
    tick();
    chk_out("np4", 1'b1, 3'd1, 8'h02, 1'b0);
    tick();
    chk_out("np5", 1'b0, 3'd0, 8'h00, 1'b0);

    // overflow and set-wins
    ready = 1'b0;
    req   = 8'h08;
    tick();
    chk_out("ov1", 1'b0, 3'd0, 8'h08, 1'b0);
    tick();
    req = 8'h00;
    chk_out("ov2", 1'b1, 3'd3, 8'h08, 1'b1);
    tick();
    chk_out("ov3", 1'b1, 3'd3, 8'h08, 1'b0);
    req = 8'h08;
    tick();
    req = 8'h00;
    chk_out("ov4", 1'b1, 3'd3, 8'h08, 1'b1);
    tick();
    chk_out("ov5", 1'b1, 3'd3, 8'h08, 1'b0);
    req   = 8'h08;
    ready = 1'b1;
    tick();
    req   = 8'h00;
    ready = 1'b0;
    chk_out("sw1", 1'b0, 3'd0, 8'h08, 1'b0);
    tick();
    chk_out("sw2", 1'b1, 3'd3, 8'h08, 1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk_out("sw3", 1'b0, 3'd0, 8'h00, 1'b0);

    // enable gating
    enable = 1'b0;
    req    = 8'hFF;
    tick();
    tick();
    chk_out("en1", 1'b0, 3'd0, 8'h00, 1'b0);
    enable = 1'b1;
    req    = 8'h0C;
    tick();
    chk_out("en2", 1'b0, 3'd0, 8'h0C, 1'b0);
    enable = 1'b0;
    req    = 8'hFF;
    ready  = 1'b1;
    tick();
    chk_out("en3", 1'b1, 3'd2, 8'h0C, 1'b0);
    tick();
    chk_out("en4", 1'b0, 3'd0, 8'h08, 1'b0);
    tick();
    chk_out("en5", 1'b1, 3'd3, 8'h08, 1'b0);
    tick();
    chk_out("en6", 1'b0, 3'd0, 8'h00, 1'b0);

    // async reset mid-handshake
    enable = 1'b1;
    req    = 8'hFF;
    ready  = 1'b0;
    tick();
    req = 8'h00;
    tick();
    chk_out("ar1", 1'b1, 3'd0, 8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk({"ar.code"}, {5'd0, code}, 8'h00);
    chk_out("ar2", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk_out("ar3", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    chk_out("ar4", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_encoder_8_3.md
# event_encoder_8_3

Registered 8-to-3 priority event encoder, the inverse of the team's 3-to-8 one-hot decoder. It captures single-cycle request pulses on 8 lines into sticky pending flags. It presents the highest-priority pending line as a 3-bit binary code over a valid/ready handshake and clears each flag when its code is accepted. It sits between event sources (buttons, peripheral strobes) and a consumer that drives a decoder or dispatcher from the code.

## Interface
- No parameters; widths are fixed at 8 request lines and a 3-bit code.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- enable  input  1  1 = capture requests; 0 = ignore new requests while still draining pending ones.
- req  input  8  request lines; bit i high at a clock edge = one event on line i.
- ready  input  1  consumer accepts the presented code when ready=1 and valid=1 at an edge.
- code  output  3  binary index of the presented line; code=i corresponds to decoder output bit i.
- valid  output  1  code is meaningful and held stable until accepted.
- pending  output  8  sticky pending flags (registered).
- overflow  output  1  one-cycle pulse: an event was merged into an already-pending flag.

## Operation
- Reset (rst_n=0, asynchronous): pending=8'h00, code=3'b000, valid=0, overflow=0, state=IDLE. These values are held while rst_n=0.
- Capture: at each edge with enable=1, pending[i] is set for every req[i]=1. With enable=0, req is ignored entirely, including for overflow.
- Priority: the lowest index wins (bit 0 highest, bit 7 lowest).
- FSM with two states:
  - IDLE (valid=0): at an edge where the pending register (the value before this edge's update) is non-zero, load code with the index of the lowest set bit and go to PRESENT with valid=1. If pending is zero, stay in IDLE.
  - PRESENT (valid=1): code and valid hold. At an edge with ready=1, clear pending[code], drop valid to 0, and go to IDLE. With ready=0, stay in PRESENT.
- No preemption: a higher-priority request arriving during PRESENT does not change code until the current code is accepted.
- Overflow: pulse for one cycle when enable=1, req[i]=1, pending[i]=1, and pending[i] is not being cleared by an accept at the same edge. The event is merged, so the count is lost; only the flag remains.
- Simultaneous set and clear on the same bit: the set wins. pending[i] stays 1 as a new event, with no overflow.
- Multiple req bits in one cycle: all are captured and then served in priority order, one per handshake.
- enable may drop at any time; already-pending flags still drain normally.

## Timing
- Latency: req[i] sampled at edge N sets pending[i] after N. From IDLE, valid=1 with code=i after edge N+1 (2 edges from request to valid).
- Throughput: at most one code per 2 cycles, because IDLE always inserts a one-cycle bubble after each accept.
- The accepting edge clears the flag, so pending[code]=0 after that edge (unless it was re-set at the same edge).
- overflow is registered and is high for exactly the one cycle after the offending edge.
- pending, code, valid and overflow are all registered outputs with no combinational path from any input.
- Asserting rst_n=0 mid-handshake immediately clears valid and pending. The consumer must discard any in-flight code.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle with pending=8'hFF and valid=1 -> all outputs are 0 immediately; after release with req=0, valid stays 0.
- Single event: enable=1, pulse req=8'h20 for one cycle, ready=1 -> valid=1 with code=3'd5 two edges later, lasting one cycle; pending goes 8'h20 then 8'h00.
- Priority and stall: pulse req=8'h91 in one cycle, ready=0 for 5 cycles, then ready=1 -> code=0 is held stable through the stall; codes 0, 4, 7 are then delivered with a one-cycle valid=0 gap between each.
- No preemption: while code=6 is presented with ready=0, pulse req[1] -> code stays 6; after it is accepted, the next code is 1.
- Overflow and set-wins: pulse req[3] twice while pending[3]=1 and not accepted -> exactly one overflow pulse per extra event. Pulse req[3] on the same edge that accepts code=3 -> no overflow, pending[3] stays 1, and code 3 is presented again.
- Enable gating: enable=0 with req=8'hFF -> pending stays 8'h00 and overflow stays 0. Set pending=8'h0C with enable=1, then drop enable -> codes 2 and 3 are still delivered.
